regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-read-port register file with an integrated write-pending scoreboard and a self-clearing initialisation sequencer. It sits in the decode/writeback stages of the pipelined datapath. It serves operand reads and forwards same-cycle writeback data to readers. It also tracks which destination registers have an in-flight producer, so the hazard unit can stall dependants.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes, is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- init_done  out  1  high once the clear sequence has finished
- RegWrite  in  1  writeback enable
- WN  in  ADDR_W  writeback register index
- WD  in  DATA_W  writeback data
- RN  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has a pending producer
- issue_valid  in  1  an instruction with a destination is issuing this cycle
- issue_rd  in  ADDR_W  destination index of the issuing instruction
- busy_vec  out  DEPTH  raw scoreboard bits, for debug and the hazard unit

## Operation
- FSM states are INIT and RUN. Reset forces INIT, clears the init counter to 0, clears busy_vec to all-0, and drives init_done to 0.
- INIT behaviour:
  - Each cycle, entry[cnt] is written to 0 and cnt is incremented.
  - When cnt == DEPTH-1 has been written, the next state is RUN. init_done is registered and goes high on that edge.
  - RegWrite and issue_valid are ignored.
  - RD outputs 0 and rd_busy outputs 0.
- RUN write: on a rising edge with RegWrite set and WN not equal to 0 (or ZERO_REG=0), entry[WN] is loaded with WD.
- RUN read (combinational, per port k):
  - If ZERO_REG and RN_k==0, RD_k = 0.
  - Otherwise, if RegWrite and WN==RN_k, RD_k = WD (bypass).
  - Otherwise, RD_k = entry[RN_k].
- Scoreboard, on a rising edge in RUN:
  - RegWrite clears busy[WN].
  - issue_valid sets busy[issue_rd].
  - If both target the same index in the same cycle, set wins, because the issue is the newer producer.
  - With ZERO_REG, index 0 is never set.
- rd_busy_k = busy[RN_k] & ~(RegWrite & WN==RN_k). A same-cycle writeback resolves the hazard because its data is bypassed.
- Reset asserted mid-RUN aborts everything immediately. After release, the clear sequence reruns and all contents are lost.

## Timing
- Reset values: init_done=0, busy_vec=0, rd_busy=0, RD=0.
- init_done rises on the DEPTH-th rising edge after reset deasserts; with the defaults this is edge 32.
- Read latency is 0 cycles (combinational). Write-to-read is visible on the same cycle via bypass, and from the array on the next cycle.
- Scoreboard set and clear take effect on the edge; busy_vec shows the change in the following cycle.
- No backpressure. Upstream must not issue or write while init_done=0; any such inputs are dropped.

## Structure
- Shared package regfile_pkg holds:
  - the FSM state enum (ST_INIT, ST_RUN)
  - default DATA_W/ADDR_W constants shared with the decode stage
- Sub-module regfile_scoreboard holds the DEPTH-bit busy vector with set/clear/priority logic and the per-port rd_busy masking. regfile_sb instantiates it and owns the array, bypass and init FSM.

## Test plan
- Reset, then hold 40 cycles -> init_done rises exactly at edge 32; every RN reads 0 both before and after init.
- RUN: write R5=0x1234 with RN0=5 in the same cycle -> RD0=0x1234 via bypass; next cycle with RegWrite=0 -> RD0=0x1234 from the array.
- Write R0=0xFFFF with ZERO_REG=1 -> RD for index 0 stays 0; busy_vec[0] stays 0 after issue_rd=0.
- Issue rd=7 -> busy_vec[7]=1, rd_busy for RN=7 is 1; writeback WN=7 with RN=7 in that cycle -> rd_busy=0 and RD=WD; next cycle busy_vec[7]=0.
- Same-cycle issue_rd=9 and writeback WN=9 with busy[9]=1 -> busy_vec[9] stays 1.
- Write R3=0xAA, assert reset mid-RUN for 1 cycle, release -> init_done=0 for 32 cycles, after which R3 reads 0 and busy_vec=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: FSM state encoding and default widths
// that the decode stage also uses.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set on issue and cleared on
// writeback, plus per-read-port hazard flags that account for same-cycle bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  state_t                   i_state,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_idx,
    input  logic                     i_set_en,
    input  logic [ADDR_W-1:0]        i_set_idx,
    input  logic [NUM_RD*ADDR_W-1:0] i_rn,
    output logic [2**ADDR_W-1:0]     o_busy_vec,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic             w_run;
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_d;

    assign w_run = (i_state == ST_RUN);

    // Set is applied after clear so a newer producer wins over a retiring one.
    always_comb begin
        w_busy_d = r_busy;
        if (i_wr_en) begin
            w_busy_d[i_wr_idx] = 1'b0;
        end
        if (i_set_en && !(ZERO_REG && (i_set_idx == '0))) begin
            w_busy_d[i_set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else if (w_run) begin
            r_busy <= w_busy_d;
        end
    end

    always_comb begin
        o_rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            o_rd_busy[k] = w_run && r_busy[i_rn[k*ADDR_W +: ADDR_W]]
                           && !(i_wr_en && (i_wr_idx == i_rn[k*ADDR_W +: ADDR_W]));
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback bypass, a self-clearing init sequence
// and an attached write-pending scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = NUM_RD_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     init_done,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WN,
    input  logic [DATA_W-1:0]        WD,
    input  logic [NUM_RD*ADDR_W-1:0] RN,
    output logic [NUM_RD*DATA_W-1:0] RD,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int unsigned       DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_run;
    logic w_wr_en;
    logic w_sb_clr;

    assign w_run    = (r_state == ST_RUN);
    assign w_sb_clr = w_run && RegWrite;
    assign w_wr_en  = w_sb_clr && !(ZERO_REG && (WN == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // The array has no reset; the INIT sweep clears it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[WN] <= WD;
        end
    end

    always_comb begin
        RD = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (w_run) begin
                if (ZERO_REG && (RN[k*ADDR_W +: ADDR_W] == '0)) begin
                    RD[k*DATA_W +: DATA_W] = '0;
                end else if (RegWrite && (WN == RN[k*ADDR_W +: ADDR_W])) begin
                    RD[k*DATA_W +: DATA_W] = WD;
                end else begin
                    RD[k*DATA_W +: DATA_W] = r_mem[RN[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_state    (r_state),
        .i_wr_en    (w_sb_clr),
        .i_wr_idx   (WN),
        .i_set_en   (issue_valid),
        .i_set_idx  (issue_rd),
        .i_rn       (RN),
        .o_busy_vec (busy_vec),
        .o_rd_busy  (rd_busy)
    );

    assign init_done = r_init_done;

endmodule
